trap_ctrl: RTL and testbench

Commit-side trap sequencer for the five-stage RV64 pipeline. It sits directly upstream of the CSR file. It watches the instruction presented at commit and selects among a pending enabled interrupt, a synchronous exception or `mret`. It then drains outstanding data-bus traffic, issues a single-cycle trap/return update to the CSR file, and redirects fetch to the handler or the return address.

---
 rtl/trap_ctrl_if.sv | 42 ++++
 rtl/trap_ctrl.sv | 140 ++++++++++++++
 tb/tb_trap_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// rtl/trap_ctrl_if.sv - commit, CSR, data-bus and trap/redirect signal bundle for trap_ctrl
interface trap_ctrl_if #(
  parameter int XLEN = 64
);
  logic            commit_valid;
  logic            commit_ready;
  logic [XLEN-1:0] commit_pc;
  logic            commit_exc_valid;
  logic [3:0]      commit_exc_code;
  logic [XLEN-1:0] commit_tval;
  logic            commit_is_mret;
  logic            csr_mstatus_mie;
  logic [XLEN-1:0] csr_mie;
  logic [XLEN-1:0] csr_mip;
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;
  logic            dbus_busy;
  logic            trap_valid;
  logic            trap_is_interrupt;
  logic            trap_is_exception;
  logic            trap_is_mret;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_tval;
  logic            flush;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output commit_valid, commit_pc, commit_exc_valid, commit_exc_code, commit_tval,
           commit_is_mret, csr_mstatus_mie, csr_mie, csr_mip, csr_mtvec, csr_mepc, dbus_busy,
    input  commit_ready, trap_valid, trap_is_interrupt, trap_is_exception, trap_is_mret,
           trap_pc, trap_cause, trap_tval, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  commit_valid, commit_pc, commit_exc_valid, commit_exc_code, commit_tval,
           commit_is_mret, csr_mstatus_mie, csr_mie, csr_mip, csr_mtvec, csr_mepc, dbus_busy,
    output commit_ready, trap_valid, trap_is_interrupt, trap_is_exception, trap_is_mret,
           trap_pc, trap_cause, trap_tval, flush, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - commit-side trap sequencer: select event, drain dbus, strobe CSR update, redirect fetch
module trap_ctrl #(
  parameter int XLEN      = 64,
  parameter int DRAIN_MAX = 15
) (
  input logic       clk,
  input logic       resetn,
  trap_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAIN, UPDATE, REDIRECT} state_t;

  localparam int CW = $clog2(DRAIN_MAX + 1);

  state_t          state, next_state;
  logic [CW-1:0]   drain_cnt;
  logic            drain_done;
  logic [XLEN-1:0] pend;
  logic            irq_take;
  logic [3:0]      irq_code;
  logic            accept;
  logic            take;
  logic [XLEN-1:0] cause_d;
  logic [XLEN-1:0] tval_d;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] target;
  logic            trap_valid_d, redirect_valid_d, flush_d;
  logic            trap_valid_q, redirect_valid_q, flush_q;
  logic            is_irq_q, is_exc_q, is_mret_q;
  logic [XLEN-1:0] trap_pc_q, trap_cause_q, trap_tval_q, redirect_pc_q;
  logic            unused_pend;

  // Only MEI/MSI/MTI are routed through here; other pending bits belong to other paths.
  assign pend        = bus.csr_mie & bus.csr_mip & {XLEN{bus.csr_mstatus_mie}};
  assign unused_pend = ^{pend[XLEN-1:12], pend[10:8], pend[6:4], pend[2:0]};
  assign irq_take    = pend[11] | pend[3] | pend[7];
  assign irq_code    = pend[11] ? 4'd11 : (pend[3] ? 4'd3 : 4'd7);

  assign accept     = bus.commit_valid && (state == IDLE);
  assign take       = accept && (irq_take || bus.commit_exc_valid || bus.commit_is_mret);
  assign drain_done = !bus.dbus_busy || (drain_cnt == CW'(DRAIN_MAX));
  assign base       = {mtvec_q[XLEN-1:2], 2'b00};

  // Cause/tval for the winning source; an interrupt masks a simultaneous exception or mret.
  always_comb begin
    cause_d = '0;
    tval_d  = '0;
    if (irq_take) begin
      cause_d = {1'b1, {(XLEN-5){1'b0}}, irq_code};
    end else if (bus.commit_exc_valid) begin
      cause_d = {{(XLEN-4){1'b0}}, bus.commit_exc_code};
      tval_d  = bus.commit_tval;
    end
  end

  // Redirect target: mepc is read live in UPDATE, mtvec comes from the acceptance snapshot.
  always_comb begin
    target = base;
    if (is_mret_q) begin
      target = bus.csr_mepc;
    end else if (is_irq_q && (mtvec_q[1:0] == 2'b01)) begin
      target = base + {{(XLEN-6){1'b0}}, trap_cause_q[3:0], 2'b00};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state: one pass IDLE -> DRAIN -> UPDATE -> REDIRECT -> IDLE per accepted event.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (take) next_state = DRAIN;
      DRAIN:    if (drain_done) next_state = UPDATE;
      UPDATE:   next_state = REDIRECT;
      REDIRECT: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output decode from the next state so the strobes and flush come out of flops.
  always_comb begin
    trap_valid_d     = (next_state == UPDATE);
    redirect_valid_d = (next_state == REDIRECT);
    flush_d          = (next_state != IDLE);
  end

  // Drain counter restarts at zero every time DRAIN is entered and saturates at the timeout.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              drain_cnt <= '0;
    else if (state != DRAIN)  drain_cnt <= '0;
    else if (!drain_done)     drain_cnt <= drain_cnt + 1'b1;
  end

  // Registered outputs and latched event fields.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      trap_valid_q     <= 1'b0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      is_irq_q         <= 1'b0;
      is_exc_q         <= 1'b0;
      is_mret_q        <= 1'b0;
      trap_pc_q        <= '0;
      trap_cause_q     <= '0;
      trap_tval_q      <= '0;
      mtvec_q          <= '0;
      redirect_pc_q    <= '0;
    end else begin
      trap_valid_q     <= trap_valid_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      if (take) begin
        is_irq_q     <= irq_take;
        is_exc_q     <= !irq_take && bus.commit_exc_valid;
        is_mret_q    <= !irq_take && !bus.commit_exc_valid && bus.commit_is_mret;
        trap_pc_q    <= bus.commit_pc;
        trap_cause_q <= cause_d;
        trap_tval_q  <= tval_d;
        mtvec_q      <= bus.csr_mtvec;
      end
      if (state == UPDATE) redirect_pc_q <= target;
    end
  end

  assign bus.commit_ready      = (state == IDLE);
  assign bus.trap_valid        = trap_valid_q;
  assign bus.trap_is_interrupt = is_irq_q;
  assign bus.trap_is_exception = is_exc_q;
  assign bus.trap_is_mret      = is_mret_q;
  assign bus.trap_pc           = trap_pc_q;
  assign bus.trap_cause        = trap_cause_q;
  assign bus.trap_tval         = trap_tval_q;
  assign bus.flush             = flush_q;
  assign bus.redirect_valid    = redirect_valid_q;
  assign bus.redirect_pc       = redirect_pc_q;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - scoreboard bench for trap_ctrl with directed vectors
module tb_trap_ctrl;
  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic [2:0]  kind;
    logic [63:0] pc;
    logic [63:0] cause;
    logic [63:0] tval;
    logic [63:0] target;
    int          tcyc;
  } exp_t;

  exp_t trap_q[$];
  exp_t redir_q[$];

  trap_ctrl_if #(.XLEN(64)) bus();

  trap_ctrl #(.XLEN(64), .DRAIN_MAX(15)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever a strobe is presented.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.trap_valid) begin
        if (trap_q.size() == 0) begin
          check("unexpected_trap_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = trap_q.pop_front();
          check("trap_kind", {61'd0, bus.trap_is_interrupt, bus.trap_is_exception, bus.trap_is_mret}, {61'd0, e.kind});
          check("trap_pc", bus.trap_pc, e.pc);
          check("trap_cause", bus.trap_cause, e.cause);
          check("trap_tval", bus.trap_tval, e.tval);
          check("trap_cycle", 64'(cyc), 64'(e.tcyc));
          check("trap_flush", {63'd0, bus.flush}, 64'd1);
        end
      end
      if (bus.redirect_valid) begin
        if (redir_q.size() == 0) begin
          check("unexpected_redirect_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = redir_q.pop_front();
          check("redirect_pc", bus.redirect_pc, e.target);
          check("redirect_cycle", 64'(cyc), 64'(e.tcyc));
          check("redirect_flush", {63'd0, bus.flush}, 64'd1);
          check("redirect_no_trap", {63'd0, bus.trap_valid}, 64'd0);
        end
      end
    end
  end

  task automatic clear_inputs();
    bus.commit_valid     = 1'b0;
    bus.commit_pc        = '0;
    bus.commit_exc_valid = 1'b0;
    bus.commit_exc_code  = '0;
    bus.commit_tval      = '0;
    bus.commit_is_mret   = 1'b0;
    bus.csr_mstatus_mie  = 1'b0;
    bus.csr_mie          = '0;
    bus.csr_mip          = '0;
    bus.csr_mtvec        = '0;
    bus.csr_mepc         = '0;
    bus.dbus_busy        = 1'b0;
  endtask

  task automatic issue(
    input logic [63:0] pc, input logic exc, input logic [3:0] code, input logic [63:0] tval,
    input logic mret, input logic mie_b, input logic [63:0] mie, input logic [63:0] mip,
    input logic [63:0] mtvec, input logic [63:0] mepc_late, input int busy,
    input logic expect_evt, input logic [2:0] ekind, input logic [63:0] ecause,
    input logic [63:0] etval, input logic [63:0] etarget, input int slip);
    int   t;
    exp_t e;
    @(negedge clk);
    bus.commit_valid     = 1'b1;
    bus.commit_pc        = pc;
    bus.commit_exc_valid = exc;
    bus.commit_exc_code  = code;
    bus.commit_tval      = tval;
    bus.commit_is_mret   = mret;
    bus.csr_mstatus_mie  = mie_b;
    bus.csr_mie          = mie;
    bus.csr_mip          = mip;
    bus.csr_mtvec        = mtvec;
    bus.csr_mepc         = 64'h1111;
    bus.dbus_busy        = (busy > 0);
    t = cyc;
    if (expect_evt) begin
      e.kind = ekind; e.pc = pc; e.cause = ecause; e.tval = etval; e.target = etarget;
      e.tcyc = t + 2 + slip;
      trap_q.push_back(e);
      e.tcyc = t + 3 + slip;
      redir_q.push_back(e);
    end
    @(negedge clk);
    // Later CSR changes must not leak into the latched event; only mepc is read late.
    bus.commit_valid     = 1'b0;
    bus.commit_exc_valid = 1'b0;
    bus.commit_is_mret   = 1'b0;
    bus.csr_mstatus_mie  = 1'b0;
    bus.csr_mie          = '0;
    bus.csr_mip          = '0;
    bus.csr_mtvec        = 64'hDEAD_BEEF_0000_0000;
    bus.csr_mepc         = mepc_late;
    check("flush_after_accept", {63'd0, bus.flush}, {63'd0, expect_evt});
    check("ready_after_accept", {63'd0, bus.commit_ready}, {63'd0, !expect_evt});
    for (int k = 1; k <= busy; k++) @(negedge clk);
    bus.dbus_busy = 1'b0;
    for (int i = 0; i < 60 && !bus.commit_ready; i++) @(negedge clk);
    check("return_idle", {63'd0, bus.commit_ready}, 64'd1);
    check("flush_idle", {63'd0, bus.flush}, 64'd0);
    if (busy == slip) check("idle_cycle", 64'(cyc - t), expect_evt ? 64'(4 + slip) : 64'd1);
  endtask

  initial begin
    clear_inputs();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'd0, bus.commit_ready}, 64'd1);
    check("rst_strobes", {61'd0, bus.trap_valid, bus.flush, bus.redirect_valid}, 64'd0);
    check("rst_kind", {61'd0, bus.trap_is_interrupt, bus.trap_is_exception, bus.trap_is_mret}, 64'd0);
    check("rst_trap_pc", bus.trap_pc, 64'd0);
    check("rst_cause", bus.trap_cause, 64'd0);
    check("rst_tval", bus.trap_tval, 64'd0);
    check("rst_redirect_pc", bus.redirect_pc, 64'd0);
    resetn = 1'b1;

    // pc, exc, code, tval, mret, MIE, mie, mip, mtvec, mepc_late, busy, evt, kind{irq,exc,mret}, cause, tval, target, slip
    issue(64'h8000_0010, 1, 4'd2, 64'h1234, 0, 0, 64'h0, 64'h0, 64'h8000_1000, 64'h0, 0,
          1, 3'b010, 64'd2, 64'h1234, 64'h8000_1000, 0);
    issue(64'h8000_0020, 0, 4'd0, 64'h5555, 0, 1, 64'h80, 64'h80, 64'h8000_1001, 64'h0, 0,
          1, 3'b100, 64'h8000_0000_0000_0007, 64'h0, 64'h8000_101C, 0);
    issue(64'h8000_0030, 1, 4'd5, 64'h77, 1, 1, 64'h888, 64'h888, 64'h8000_1000, 64'h0, 0,
          1, 3'b100, 64'h8000_0000_0000_000B, 64'h0, 64'h8000_1000, 0);
    issue(64'h8000_0040, 0, 4'd0, 64'h0, 1, 1, 64'h0, 64'h0, 64'h8000_1000, 64'h8000_0204, 0,
          1, 3'b001, 64'h0, 64'h0, 64'h8000_0204, 0);
    issue(64'h8000_0048, 0, 4'd0, 64'h0, 1, 0, 64'h800, 64'h800, 64'h8000_1000, 64'h8000_0300, 0,
          1, 3'b001, 64'h0, 64'h0, 64'h8000_0300, 0);
    issue(64'h8000_0050, 1, 4'd5, 64'hABC, 0, 0, 64'h0, 64'h0, 64'h8000_2000, 64'h0, 5,
          1, 3'b010, 64'd5, 64'hABC, 64'h8000_2000, 5);
    issue(64'h8000_0060, 1, 4'd7, 64'hF00, 0, 0, 64'h0, 64'h0, 64'h8000_2000, 64'h0, 40,
          1, 3'b010, 64'd7, 64'hF00, 64'h8000_2000, 15);
    issue(64'h8000_0070, 0, 4'd0, 64'h0, 0, 1, 64'h8, 64'h8, 64'h8000_1001, 64'h0, 0,
          1, 3'b100, 64'h8000_0000_0000_0003, 64'h0, 64'h8000_100C, 0);
    issue(64'h8000_0080, 1, 4'd4, 64'h99, 0, 0, 64'h80, 64'h80, 64'h8000_1001, 64'h0, 0,
          1, 3'b010, 64'd4, 64'h99, 64'h8000_1000, 0);
    issue(64'h8000_0090, 0, 4'd0, 64'h0, 0, 1, 64'h800, 64'h800, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0, 0,
          1, 3'b100, 64'h8000_0000_0000_000B, 64'h0, 64'h0000_0000_0000_0028, 0);
    // Plain retirements: interrupt masked, no mie/mip overlap, non-routed pending bit.
    issue(64'h8000_00A0, 0, 4'd0, 64'h0, 0, 0, 64'h80, 64'h80, 64'h8000_1000, 64'h0, 0,
          0, 3'b000, 64'h0, 64'h0, 64'h0, 0);
    issue(64'h8000_00A4, 0, 4'd0, 64'h0, 0, 1, 64'h80, 64'h08, 64'h8000_1000, 64'h0, 0,
          0, 3'b000, 64'h0, 64'h0, 64'h0, 0);
    issue(64'h8000_00A8, 0, 4'd0, 64'h0, 0, 1, 64'h2, 64'h2, 64'h8000_1000, 64'h0, 0,
          0, 3'b000, 64'h0, 64'h0, 64'h0, 0);

    // Reset pulsed while draining: everything drops at once and nothing is emitted afterwards.
    @(negedge clk);
    bus.commit_valid     = 1'b1;
    bus.commit_pc        = 64'h8000_00B0;
    bus.commit_exc_valid = 1'b1;
    bus.commit_exc_code  = 4'd2;
    bus.csr_mtvec        = 64'h8000_1000;
    bus.dbus_busy        = 1'b1;
    @(negedge clk);
    bus.commit_valid     = 1'b0;
    bus.commit_exc_valid = 1'b0;
    check("drain_flush_before_reset", {63'd0, bus.flush}, 64'd1);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("async_rst_strobes", {61'd0, bus.trap_valid, bus.flush, bus.redirect_valid}, 64'd0);
    check("async_rst_ready", {63'd0, bus.commit_ready}, 64'd1);
    check("async_rst_trap_pc", bus.trap_pc, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    bus.dbus_busy = 1'b0;
    repeat (20) @(negedge clk);
    check("post_rst_ready", {63'd0, bus.commit_ready}, 64'd1);
    check("post_rst_flush", {63'd0, bus.flush}, 64'd0);

    repeat (3) @(negedge clk);
    check("trap_q_drained", 64'(trap_q.size()), 64'd0);
    check("redir_q_drained", 64'(redir_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
